// File: rtl/regfile_pkg.sv
// ============================================================================
// Module : regfile_pkg
// Brief  : Register-file geometry constants and the staged-write record type.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int RF_ADDR_W   = 5;
  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 32;
  localparam logic [RF_ADDR_W-1:0] X0_ADDR = 5'd0;

  typedef struct packed {
    logic                 we;
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_t;

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin grant; search starts at ptr_i and wraps.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int off = 0; off < N; off++) begin
      // ptr + off never exceeds 2N-2, so a single subtraction wraps it
      cand = {1'b0, ptr_i} + (IDX_W+1)'(off);
      if (cand >= (IDX_W+1)'(N)) begin
        cand = cand - (IDX_W+1)'(N);
      end
      if (!any_o && req_i[cand[IDX_W-1:0]]) begin
        any_o                     = 1'b1;
        gnt_o[cand[IDX_W-1:0]]    = 1'b1;
        idx_o                     = cand[IDX_W-1:0];
      end
    end
  end

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module : regfile_wb_arbiter
// Brief  : Round-robin share of the register-file write port with one output
//          stage. Optional forwarding enabled by REGFILE_WB_BYPASS_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = RF_DATA_W,
  parameter int ADDR_W  = RF_ADDR_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
`ifdef REGFILE_WB_BYPASS_EN
  input  logic [ADDR_W-1:0]           byp_a1,
  input  logic [ADDR_W-1:0]           byp_a2,
  input  logic [DATA_W-1:0]           byp_rd1_in,
  input  logic [DATA_W-1:0]           byp_rd2_in,
  output logic [DATA_W-1:0]           byp_rd1,
  output logic [DATA_W-1:0]           byp_rd2,
`endif
  output logic                        rf_we,
  output logic [ADDR_W-1:0]           rf_waddr,
  output logic [DATA_W-1:0]           rf_wdata,
  output logic [(2**ADDR_W)-1:0]      pend_mask
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [ADDR_W-1:0]  src_addr [NUM_REQ];
  logic [DATA_W-1:0]  src_data [NUM_REQ];

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic               xfer;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]  rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]  rf_wdata_q, rf_wdata_d;

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign src_addr[i] = req_addr[i*ADDR_W +: ADDR_W];
      assign src_data[i] = req_data[i*DATA_W +: DATA_W];
    end
  endgenerate

  assign arb_req = req_valid & {NUM_REQ{~stall}};

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req_i (arb_req),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  // Ready is gated directly by the async reset so no grant escapes during it
  assign req_ready = arb_gnt & {NUM_REQ{reset}};
  assign xfer      = gnt_any & reset;
  assign sel_addr  = src_addr[gnt_idx];
  assign sel_data  = src_data[gnt_idx];

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (xfer) begin
      rr_ptr_d   = (gnt_idx == IDX_W'(NUM_REQ-1)) ? '0 : gnt_idx + IDX_W'(1);
      rf_we_d    = (sel_addr != ADDR_W'(X0_ADDR));
      rf_waddr_d = sel_addr;
      rf_wdata_d = sel_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  always_comb begin
    pend_mask = '0;
    if (rf_we_q) begin
      pend_mask[rf_waddr_q] = 1'b1;
    end
  end

`ifdef REGFILE_WB_BYPASS_EN
  assign byp_rd1 = (rf_we_q && (rf_waddr_q == byp_a1) && (byp_a1 != ADDR_W'(X0_ADDR)))
                   ? rf_wdata_q : byp_rd1_in;
  assign byp_rd2 = (rf_we_q && (rf_waddr_q == byp_a2) && (byp_a2 != ADDR_W'(X0_ADDR)))
                   ? rf_wdata_q : byp_rd2_in;
`endif

endmodule : regfile_wb_arbiter

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// Module : tb_regfile_wb_arbiter
// Brief  : Scoreboarded bench: directed scenarios plus randomized sources.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int N  = 3;
  localparam int AW = RF_ADDR_W;
  localparam int DW = RF_DATA_W;

  logic              clk   = 1'b0;
  logic              reset = 1'b1;
  logic              stall = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N*AW-1:0]   req_addr  = '0;
  logic [N*DW-1:0]   req_data  = '0;
  logic [N-1:0]      req_ready;
  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [DW-1:0]     rf_wdata;
  logic [(2**AW)-1:0] pend_mask;
`ifdef REGFILE_WB_BYPASS_EN
  logic [AW-1:0]     byp_a1 = '0, byp_a2 = '0;
  logic [DW-1:0]     byp_rd1_in = '0, byp_rd2_in = '0;
  logic [DW-1:0]     byp_rd1, byp_rd2;
`endif

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
`ifdef REGFILE_WB_BYPASS_EN
    .byp_a1    (byp_a1),
    .byp_a2    (byp_a2),
    .byp_rd1_in(byp_rd1_in),
    .byp_rd2_in(byp_rd2_in),
    .byp_rd1   (byp_rd1),
    .byp_rd2   (byp_rd2),
`endif
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .pend_mask (pend_mask)
  );

  // Register file driven by the DUT write port
  logic [DW-1:0] rf [RF_NUM_REGS] = '{default: '0};
  always @(posedge clk) if (rf_we && rf_waddr != '0) rf[rf_waddr] <= rf_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int due; rf_wr_t exp; } item_t;
  item_t q[$];

  int      n_pass = 0, n_tot = 0;
  int      m_ptr  = 0;
  rf_wr_t  m_stage = '0;
  logic [DW-1:0] m_rf [RF_NUM_REGS] = '{default: '0};
  logic          pend_v = 1'b0;
  logic [AW-1:0] pend_a = '0;
  logic [DW-1:0] pend_d = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // One clock of stimulus; entered and left at posedge+1
  task automatic step(input logic [N-1:0] v, input logic [N*AW-1:0] a,
                      input logic [N*DW-1:0] d, input logic s, output int winner);
    logic [N-1:0] exp_rdy;
    req_valid = v; req_addr = a; req_data = d; stall = s;
    #1;
    winner = -1;
    if (!s) begin
      for (int k = 0; k < N; k++) begin
        if (winner < 0 && v[(m_ptr + k) % N]) winner = (m_ptr + k) % N;
      end
    end
    exp_rdy = (winner < 0) ? '0 : N'(1) << winner;
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    if (winner >= 0) begin
      m_stage.addr = a[winner*AW +: AW];
      m_stage.data = d[winner*DW +: DW];
      m_stage.we   = (m_stage.addr != X0_ADDR);
      m_ptr        = (winner + 1) % N;
    end else begin
      m_stage.we = 1'b0;
    end
    q.push_back('{due: cyc + 1, exp: m_stage});
    @(posedge clk); #1;
  endtask

  // Monitor: compares the output stage with the scoreboard entry due this cycle
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due < cyc) begin
        it = q.pop_front();
        check("sb_stale", 64'(it.due), 64'(cyc));
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        it = q.pop_front();
        if (pend_v) m_rf[pend_a] = pend_d;
        pend_v = 1'b0;
        check("rf_we",     64'(rf_we),    64'(it.exp.we));
        check("rf_waddr",  64'(rf_waddr), 64'(it.exp.addr));
        check("rf_wdata",  64'(rf_wdata), 64'(it.exp.data));
        check("pend_mask", 64'(pend_mask), it.exp.we ? (64'(1) << it.exp.addr) : 64'(0));
        if (it.exp.we) begin
          pend_v = 1'b1; pend_a = it.exp.addr; pend_d = it.exp.data;
        end
      end
    end
  end

  logic [N-1:0]  sv;
  logic [AW-1:0] sa [N];
  logic [DW-1:0] sd [N];

  task automatic random_cycles(input int count);
    int w;
    logic [N*AW-1:0] pa;
    logic [N*DW-1:0] pd;
    for (int c = 0; c < count; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!sv[i] && $urandom_range(0, 1) == 1) begin
          sv[i] = 1'b1;
          sa[i] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31));
          sd[i] = $urandom;
        end else if (sv[i] && $urandom_range(0, 15) == 0) begin
          sv[i] = 1'b0;
        end
        pa[i*AW +: AW] = sa[i];
        pd[i*DW +: DW] = sd[i];
      end
      step(sv, pa, pd, ($urandom_range(0, 7) == 0), w);
      if (w >= 0) sv[w] = 1'b0;
    end
  endtask

  initial begin
    int w;
    int exp_seq [4] = '{0, 1, 2, 0};
    sv = '0;
    for (int i = 0; i < N; i++) begin sa[i] = '0; sd[i] = '0; end

    // Reset with all sources requesting
    #1 reset = 1'b0;
    req_valid = 3'b111;
    #12;
    check("rst_ready", 64'(req_ready), 64'(0));
    check("rst_we",    64'(rf_we),     64'(0));
    check("rst_pend",  64'(pend_mask), 64'(0));
    @(posedge clk); #1 reset = 1'b1;

    // All three continuously valid
    for (int k = 0; k < 4; k++) begin
      step(3'b111, {5'd3, 5'd2, 5'd1}, {32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA}, 1'b0, w);
      check("t2_grant", 64'(w), 64'(exp_seq[k]));
    end

    // x0 write from src1
    step(3'b010, '0, {32'h0, 32'hFFFF_FFFF, 32'h0}, 1'b0, w);
    check("t3_grant", 64'(w), 64'(1));

    // Same address from src0 and src2 with the pointer at 2
    step(3'b101, {5'd8, 5'd0, 5'd8}, {32'h2222, 32'h0, 32'h1111}, 1'b0, w);
    check("t4_first", 64'(w), 64'(2));
    step(3'b001, {5'd0, 5'd0, 5'd8}, {32'h0, 32'h0, 32'h1111}, 1'b0, w);
    check("t4_second", 64'(w), 64'(0));
    step(3'b000, '0, '0, 1'b0, w);
    check("t4_reg8", 64'(rf[8]), 64'(32'h1111));

    // Stall holds off src1
    for (int k = 0; k < 3; k++) begin
      step(3'b010, {5'd0, 5'd9, 5'd0}, {32'h0, 32'h5A5A_5A5A, 32'h0}, 1'b1, w);
      check("t5_stalled", 64'(w + 1), 64'(0));
    end
    step(3'b010, {5'd0, 5'd9, 5'd0}, {32'h0, 32'h5A5A_5A5A, 32'h0}, 1'b0, w);
    check("t5_release", 64'(w), 64'(1));

    random_cycles(300);

    // Reset while a write to x5 is staged
    sv = '0;
    step(3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hDEAD}, 1'b0, w);
    req_valid = 3'b111;
`ifdef REGFILE_WB_BYPASS_EN
    byp_a1 = 5'd5; byp_rd1_in = 32'h1234_5678;
    #1;
    check("byp_rd1", 64'(byp_rd1), 64'(32'hDEAD));
    byp_a1 = 5'd0;
`endif
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    check("t6_we",    64'(rf_we),     64'(0));
    check("t6_pend",  64'(pend_mask), 64'(0));
    check("t6_ready", 64'(req_ready), 64'(0));
    pend_v = 1'b0;
    q.delete();
    m_ptr = 0;
    m_stage = '0;
    req_valid = '0;
    @(posedge clk); @(posedge clk);
    check("t6_x5", 64'(rf[5]), 64'(m_rf[5]));
    #1 reset = 1'b1;

    random_cycles(200);
    sv = '0;
    for (int k = 0; k < 3; k++) step('0, '0, '0, 1'b0, w);
    @(negedge clk); #1;
    if (pend_v) begin m_rf[pend_a] = pend_d; pend_v = 1'b0; end
    check("sb_drained", 64'(q.size()), 64'(0));
    for (int r = 1; r < RF_NUM_REGS; r++) check($sformatf("rf_x%0d", r), 64'(rf[r]), 64'(m_rf[r]));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule : tb_regfile_wb_arbiter

`default_nettype wire
